// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 NRZ line decoder producing 24-bit GRB pixels, frame-end and error pulses.
// Define WS2812_RX_FWD_EN to forward every pixel after the first on d_fwd (chain element).
module ws2812_rx #(
   parameter int BIT_THRESH = 60,
   parameter int MIN_HIGH   = 15,
   parameter int MAX_HIGH   = 150,
   parameter int TRES       = 5000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       d_in,
   output logic [7:0] green,
   output logic [7:0] red,
   output logic [7:0] blue,
   output logic       pix_valid,
   output logic [9:0] pix_idx,
   output logic       frame_done,
   output logic       err,
   output logic       d_fwd
);
   localparam logic [2:0] SYNC      = 3'd0;
   localparam logic [2:0] WAIT_HIGH = 3'd1;
   localparam logic [2:0] HIGH      = 3'd2;
   localparam logic [2:0] LOW       = 3'd3;
   localparam logic [2:0] ERR       = 3'd4;
   localparam logic [15:0] BIT_C  = 16'(BIT_THRESH);
   localparam logic [15:0] MIN_C  = 16'(MIN_HIGH);
   localparam logic [15:0] MAX_C  = 16'(MAX_HIGH);
   localparam logic [15:0] TRES_C = 16'(TRES);

   logic        sync1_q, sync1_d, s_in_q, s_in_d, prev_q, prev_d;
   logic [2:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d, cnt_inc;
   logic [23:0] shift_q, shift_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [9:0]  pix_cnt_q, pix_cnt_d;
   logic [7:0]  green_q, green_d, red_q, red_d, blue_q, blue_d;
   logic [9:0]  pix_idx_q, pix_idx_d;
   logic        pix_valid_q, pix_valid_d, frame_done_q, frame_done_d, err_q, err_d;
   logic        rise, fall;

   assign rise    = s_in_q & ~prev_q;
   assign fall    = ~s_in_q & prev_q;
   assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   always_comb begin
      sync1_d      = d_in;
      s_in_d       = sync1_q;
      prev_d       = s_in_q;
      state_d      = state_q;
      cnt_d        = cnt_inc;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      pix_cnt_d    = pix_cnt_q;
      green_d      = green_q;
      red_d        = red_q;
      blue_d       = blue_q;
      pix_idx_d    = pix_idx_q;
      pix_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      err_d        = 1'b0;
      case (state_q)
         SYNC, ERR: begin
            cnt_d = s_in_q ? 16'd0 : cnt_inc;
            if (!s_in_q && cnt_inc >= TRES_C) state_d = WAIT_HIGH;
         end
         WAIT_HIGH: begin
            if (rise) begin
               state_d = HIGH;
               cnt_d   = 16'd1;
            end
         end
         HIGH: begin
            if ((fall && cnt_q < MIN_C) || (!fall && cnt_inc > MAX_C)) begin
               state_d   = ERR;
               err_d     = 1'b1;
               cnt_d     = 16'd0;
               bit_cnt_d = 5'd0;
               pix_cnt_d = 10'd0;
            end else if (fall) begin
               state_d   = LOW;
               cnt_d     = 16'd1;
               shift_d   = {shift_q[22:0], cnt_q >= BIT_C};
               bit_cnt_d = (bit_cnt_q == 5'd23) ? 5'd0 : bit_cnt_q + 5'd1;
               // 24th bit: outputs are registered, so they appear the cycle after the fall
               if (bit_cnt_q == 5'd23) begin
                  green_d     = shift_d[23:16];
                  red_d       = shift_d[15:8];
                  blue_d      = shift_d[7:0];
                  pix_valid_d = 1'b1;
                  pix_idx_d   = pix_cnt_q;
                  pix_cnt_d   = (&pix_cnt_q) ? pix_cnt_q : pix_cnt_q + 10'd1;
               end
            end
         end
         LOW: begin
            if (rise) begin
               state_d = HIGH;
               cnt_d   = 16'd1;
            end else if (cnt_inc >= TRES_C) begin
               state_d      = WAIT_HIGH;
               frame_done_d = (bit_cnt_q == 5'd0);
               err_d        = (bit_cnt_q != 5'd0);
               bit_cnt_d    = 5'd0;
               pix_cnt_d    = 10'd0;
            end
         end
         default: state_d = SYNC;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q      <= 1'b0;
         s_in_q       <= 1'b0;
         prev_q       <= 1'b0;
         state_q      <= SYNC;
         cnt_q        <= 16'd0;
         shift_q      <= 24'd0;
         bit_cnt_q    <= 5'd0;
         pix_cnt_q    <= 10'd0;
         green_q      <= 8'd0;
         red_q        <= 8'd0;
         blue_q       <= 8'd0;
         pix_idx_q    <= 10'd0;
         pix_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         s_in_q       <= s_in_d;
         prev_q       <= prev_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         pix_cnt_q    <= pix_cnt_d;
         green_q      <= green_d;
         red_q        <= red_d;
         blue_q       <= blue_d;
         pix_idx_q    <= pix_idx_d;
         pix_valid_q  <= pix_valid_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   assign green      = green_q;
   assign red        = red_q;
   assign blue       = blue_q;
   assign pix_valid  = pix_valid_q;
   assign pix_idx    = pix_idx_q;
   assign frame_done = frame_done_q;
   assign err        = err_q;

`ifdef WS2812_RX_FWD_EN
   logic fwd_en_q, fwd_en_d, d_fwd_q, d_fwd_d;

   // Forwarding opens once this frame's first pixel is consumed and closes at frame end.
   always_comb begin
      fwd_en_d = (frame_done_d || err_d) ? 1'b0 : (pix_valid_d ? 1'b1 : fwd_en_q);
      d_fwd_d  = fwd_en_d & s_in_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fwd_en_q <= 1'b0;
         d_fwd_q  <= 1'b0;
      end else begin
         fwd_en_q <= fwd_en_d;
         d_fwd_q  <= d_fwd_d;
      end
   end

   assign d_fwd = d_fwd_q;
`else
   assign d_fwd = 1'b0;
`endif
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: randomized pulse-train stimulus for ws2812_rx checked against a pixel/frame event model.
// Define WS2812_RX_FWD_EN to also check the forwarded line.
module tb_ws2812_rx;
   localparam int GAP = 5050;

   logic       clk = 1'b0;
   logic       reset, d_in;
   logic [7:0] green, red, blue;
   logic       pix_valid, frame_done, err, d_fwd;
   logic [9:0] pix_idx;

   int total = 0, bad = 0;
   int cyc = 0, n_fd = 0, n_err = 0, exp_fd = 0, exp_err = 0, fwd_t0 = 0;
   int exp_idx = 0;
   logic din_p = 1'b0, fwd_p = 1'b0;
   logic [33:0] got_q[$], exp_q[$];
   int in_rise[$], fwd_rise[$], fwd_w[$], hi_log[$];
   int n;
   logic [23:0] px;

   ws2812_rx dut (
      .clk(clk), .reset(reset), .d_in(d_in), .green(green), .red(red), .blue(blue),
      .pix_valid(pix_valid), .pix_idx(pix_idx), .frame_done(frame_done), .err(err), .d_fwd(d_fwd)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (pix_valid) got_q.push_back({green, red, blue, pix_idx});
      if (frame_done) n_fd++;
      if (err) n_err++;
      if (d_in && !din_p) in_rise.push_back(cyc);
      if (d_fwd && !fwd_p) begin
         fwd_rise.push_back(cyc);
         fwd_t0 = cyc;
      end
      if (!d_fwd && fwd_p) fwd_w.push_back(cyc - fwd_t0);
      din_p = d_in;
      fwd_p = d_fwd;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic gap(input int k);
      d_in = 1'b0;
      tick(k);
   endtask

   task automatic send_bit(input int hi, input int lo);
      hi_log.push_back(hi);
      d_in = 1'b1;
      tick(hi);
      d_in = 1'b0;
      tick(lo);
   endtask

   // mode 0: nominal 40/85 and 80/45; 1: fast; 2: random legal widths; 3: exact width boundaries
   task automatic send_bits(input logic [23:0] p, input int nb, input int mode);
      logic b;
      int hi, lo;
      for (int i = 23; i > 23 - nb; i--) begin
         b = p[i];
         lo = 20;
         case (mode)
            0: begin hi = b ? 80 : 40; lo = b ? 45 : 85; end
            1: hi = b ? 70 : 20;
            2: begin
               hi = b ? int'($urandom_range(110, 60)) : int'($urandom_range(59, 15));
               lo = int'($urandom_range(40, 12));
            end
            default: hi = b ? ($urandom_range(1, 0) != 0 ? 150 : 60) : ($urandom_range(1, 0) != 0 ? 59 : 15);
         endcase
         send_bit(hi, lo);
      end
   endtask

   task automatic send_px(input logic [23:0] p, input int mode);
      send_bits(p, 24, mode);
   endtask

   task automatic exp_pix(input logic [23:0] p);
      exp_q.push_back({p, 10'(exp_idx)});
      exp_idx = (exp_idx == 1023) ? 1023 : exp_idx + 1;
   endtask

   task automatic exp_end();
      exp_fd++;
      exp_idx = 0;
   endtask

   task automatic exp_bad();
      exp_err++;
      exp_idx = 0;
   endtask

   task automatic settle(input string tag);
      chk({tag, ".npix"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk({tag, ".pix"}, 64'(got_q[i]), 64'(exp_q[i]));
      chk({tag, ".frame_done"}, 64'(n_fd), 64'(exp_fd));
      chk({tag, ".err"}, 64'(n_err), 64'(exp_err));
      got_q.delete();
      exp_q.delete();
      n_fd = 0;
      n_err = 0;
      exp_fd = 0;
      exp_err = 0;
   endtask

   initial begin
      reset = 1'b0;
      d_in = 1'b0;
      tick(3);
      chk("rst.out", 64'({green, red, blue, pix_idx, pix_valid, frame_done, err, d_fwd}), 64'd0);
      reset = 1'b1;
      tick(5000);

      send_px(24'hCB2C21, 0);
      exp_pix(24'hCB2C21);
      exp_end();
      gap(GAP);
      settle("px1");
      chk("px1.green", 64'(green), 64'h CB);
      chk("px1.red", 64'(red), 64'h2C);
      chk("px1.blue", 64'(blue), 64'h21);

      send_px(24'h66B2FF, 1);
      send_px(24'h000000, 1);
      exp_pix(24'h66B2FF);
      exp_pix(24'h000000);
      exp_end();
      gap(GAP);
      settle("px2");

      send_bits(24'hA5A5A5, 5, 1);
      send_bit(10, 20);
      exp_bad();
      gap(GAP);
      send_px(24'hFFFFFF, 1);
      exp_pix(24'hFFFFFF);
      exp_end();
      gap(GAP);
      settle("glitch");

      send_bits(24'h123456, 12, 1);
      exp_bad();
      gap(GAP);
      settle("partial");
      chk("partial.hold", 64'({green, red, blue}), 64'hFFFFFF);

      send_bits(24'h0F0F0F, 3, 1);
      send_bit(151, 20);
      exp_bad();
      gap(GAP);
      settle("long");

      send_bits(24'h5A5A5A, 9, 1);
      d_in = 1'b1;
      tick(20);
      reset = 1'b0;
      tick(3);
      chk("rst.mid", 64'({green, red, blue, pix_idx, pix_valid, frame_done, err, d_fwd}), 64'd0);
      reset = 1'b1;
      tick(20);
      gap(30);
      send_px(24'h00FF00, 1);
      gap(GAP);
      px = 24'($urandom);
      send_px(px, 3);
      exp_pix(px);
      exp_end();
      gap(GAP);
      settle("rst");

      for (int f = 0; f < 2; f++) begin
         n = int'($urandom_range(3, 1));
         for (int p = 0; p < n; p++) begin
            px = 24'($urandom);
            send_px(px, 2);
            exp_pix(px);
         end
         exp_end();
         gap(GAP);
         settle("rnd");
      end

`ifdef WS2812_RX_FWD_EN
      in_rise.delete();
      fwd_rise.delete();
      fwd_w.delete();
      hi_log.delete();
      for (int p = 0; p < 2; p++) begin
         px = 24'($urandom);
         send_px(px, 2);
         exp_pix(px);
      end
      exp_end();
      gap(GAP);
      settle("fwd");
      chk("fwd.npulse", 64'(fwd_w.size()), 64'd24);
      for (int i = 0; i < fwd_w.size() && i < 24; i++) begin
         chk("fwd.width", 64'(fwd_w[i]), 64'(hi_log[24 + i]));
         chk("fwd.lat", 64'(fwd_rise[i] - in_rise[24 + i]), 64'd3);
      end
      chk("fwd.idle", 64'(d_fwd), 64'd0);
`else
      chk("fwd.off", 64'(fwd_rise.size()), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
